// File: rtl/traffic_lite_timed.sv
// traffic_lite_timed: two-way car-sensor intersection controller with
// minimum/maximum green timing, yellow and all-red clearance phases.
// Optional pedestrian walk phase is compiled in with `define TRAFFIC_PED_EN.
// Lamp encoding: 2'b00 red, 2'b01 yellow, 2'b10 green.

module traffic_lite_timed #(
`ifdef TRAFFIC_PED_EN
    parameter int WALK_T    = 3,
`endif
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             EWCar,
    input  logic             NSCar,
`ifdef TRAFFIC_PED_EN
    input  logic             ped_req,
`endif
    output logic [1:0]       EWLite,
    output logic [1:0]       NSLite,
`ifdef TRAFFIC_PED_EN
    output logic             walk,
`endif
    output logic [CNT_W-1:0] phase_t
);

    typedef enum logic [2:0] {
        EW_G,
        EW_Y,
        AR_NS,
        NS_G,
        NS_Y,
        AR_EW
`ifdef TRAFFIC_PED_EN
        ,
        WALK_NS,
        WALK_EW
`endif
    } state_t;

    localparam logic [1:0] LAMP_R = 2'b00;
    localparam logic [1:0] LAMP_Y = 2'b01;
    localparam logic [1:0] LAMP_G = 2'b10;

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
`ifdef TRAFFIC_PED_EN
    localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [1:0]       ew_lite_q, ew_lite_d;
    logic [1:0]       ns_lite_q, ns_lite_d;
    logic             req_ns, req_ew;
    logic             yel_to_walk;

`ifdef TRAFFIC_PED_EN
    logic ped_pend_q;
    logic walk_q;
    logic enter_walk;
`endif

    // Cross-traffic requests seen by each green (pending pedestrians count as both).
    always_comb begin
        req_ns      = NSCar;
        req_ew      = EWCar;
        yel_to_walk = 1'b0;
`ifdef TRAFFIC_PED_EN
        req_ns      = NSCar | ped_pend_q;
        req_ew      = EWCar | ped_pend_q;
        yel_to_walk = ped_pend_q;
`endif
    end

    // Next-state logic, phase timer and lamp decode of the next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EW_G: if (phase_q >= GMIN_M1 && req_ns && (!EWCar || phase_q >= GMAX_M1))
                      state_d = EW_Y;
            NS_G: if (phase_q >= GMIN_M1 && req_ew && (!NSCar || phase_q >= GMAX_M1))
                      state_d = NS_Y;
`ifdef TRAFFIC_PED_EN
            EW_Y: if (phase_q == YEL_M1) state_d = yel_to_walk ? WALK_NS : AR_NS;
            NS_Y: if (phase_q == YEL_M1) state_d = yel_to_walk ? WALK_EW : AR_EW;
            WALK_NS: if (phase_q == WALK_M1) state_d = AR_NS;
            WALK_EW: if (phase_q == WALK_M1) state_d = AR_EW;
`else
            EW_Y: if (phase_q == YEL_M1 && !yel_to_walk) state_d = AR_NS;
            NS_Y: if (phase_q == YEL_M1 && !yel_to_walk) state_d = AR_EW;
`endif
            AR_NS: if (phase_q == AR_M1) state_d = NS_G;
            AR_EW: if (phase_q == AR_M1) state_d = EW_G;
            default: state_d = EW_G;
        endcase

        if (state_d != state_q)
            phase_d = '0;
        else if ((state_q == EW_G || state_q == NS_G) && phase_q == GMAX_M1)
            phase_d = phase_q;
        else
            phase_d = phase_q + CNT_W'(1);

        ew_lite_d = LAMP_R;
        ns_lite_d = LAMP_R;
        unique case (state_d)
            EW_G:    ew_lite_d = LAMP_G;
            EW_Y:    ew_lite_d = LAMP_Y;
            NS_G:    ns_lite_d = LAMP_G;
            NS_Y:    ns_lite_d = LAMP_Y;
            default: ;
        endcase
    end

`ifdef TRAFFIC_PED_EN
    assign enter_walk = (state_d == WALK_NS || state_d == WALK_EW) && (state_d != state_q);
`endif

    // State, timer and registered lamp outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= EW_G;
            phase_q   <= '0;
            ew_lite_q <= LAMP_G;
            ns_lite_q <= LAMP_R;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ew_lite_q <= ew_lite_d;
            ns_lite_q <= ns_lite_d;
        end
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian request latch and registered walk lamp.
    always_ff @(posedge clock) begin
        if (reset) begin
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            if (enter_walk)
                ped_pend_q <= 1'b0;
            else if (ped_req)
                ped_pend_q <= 1'b1;
            walk_q <= (state_d == WALK_NS || state_d == WALK_EW);
        end
    end

    assign walk = walk_q;
`endif

    assign EWLite  = ew_lite_q;
    assign NSLite  = ns_lite_q;
    assign phase_t = phase_q;

endmodule

// File: tb/tb_traffic_lite_timed.sv
// Directed testbench for traffic_lite_timed (default parameters).
// Define TRAFFIC_PED_EN to also exercise the pedestrian walk phase.

module tb_traffic_lite_timed;

    logic       clock = 1'b0;
    logic       reset;
    logic       EWCar;
    logic       NSCar;
    logic [1:0] EWLite;
    logic [1:0] NSLite;
    logic [7:0] phase_t;
`ifdef TRAFFIC_PED_EN
    logic       ped_req;
    logic       walk;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    traffic_lite_timed dut (
        .clock   (clock),
        .reset   (reset),
        .EWCar   (EWCar),
        .NSCar   (NSCar),
`ifdef TRAFFIC_PED_EN
        .ped_req (ped_req),
`endif
        .EWLite  (EWLite),
        .NSLite  (NSLite),
`ifdef TRAFFIC_PED_EN
        .walk    (walk),
`endif
        .phase_t (phase_t)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_excl(input int c);
        check($sformatf("excl c%0d", c), int'(EWLite != 2'b00 && NSLite != 2'b00), 0);
    endtask

    initial begin
        int ew_e, ns_e, ph_e, p;
        reset = 1'b1;
        EWCar = 1'b0;
        NSCar = 1'b0;
`ifdef TRAFFIC_PED_EN
        ped_req = 1'b0;
`endif

        // 1: no cars, EW green holds, phase saturates at 11.
        do_reset();
        check("rst ew", int'(EWLite), 2);
        check("rst ns", int'(NSLite), 0);
        check("rst ph", int'(phase_t), 0);
        for (int c = 0; c < 30; c++) begin
            check($sformatf("t1 ew c%0d", c), int'(EWLite), 2);
            check($sformatf("t1 ns c%0d", c), int'(NSLite), 0);
            check($sformatf("t1 ph c%0d", c), int'(phase_t), (c < 11) ? c : 11);
            tick();
        end

        // 2: NS car only -> green 0-3, yellow 4-5, all-red 6, NS green from 7.
        do_reset();
        NSCar = 1'b1;
        for (int c = 0; c < 12; c++) begin
            ew_e = (c <= 3) ? 2 : (c <= 5) ? 1 : 0;
            ns_e = (c >= 7) ? 2 : 0;
            ph_e = (c <= 3) ? c : (c <= 5) ? c - 4 : (c == 6) ? 0 : c - 7;
            check($sformatf("t2 ew c%0d", c), int'(EWLite), ew_e);
            check($sformatf("t2 ns c%0d", c), int'(NSLite), ns_e);
            check($sformatf("t2 ph c%0d", c), int'(phase_t), ph_e);
            tick();
        end

        // 3: both cars held -> 30-cycle period of 12 G, 2 Y, 1 AR per side.
        do_reset();
        EWCar = 1'b1;
        NSCar = 1'b1;
        for (int c = 0; c < 65; c++) begin
            p = c % 30;
            if (p < 12)      begin ew_e = 2; ns_e = 0; ph_e = p;      end
            else if (p < 14) begin ew_e = 1; ns_e = 0; ph_e = p - 12; end
            else if (p < 15) begin ew_e = 0; ns_e = 0; ph_e = 0;      end
            else if (p < 27) begin ew_e = 0; ns_e = 2; ph_e = p - 15; end
            else if (p < 29) begin ew_e = 0; ns_e = 1; ph_e = p - 27; end
            else             begin ew_e = 0; ns_e = 0; ph_e = 0;      end
            check($sformatf("t3 ew c%0d", c), int'(EWLite), ew_e);
            check($sformatf("t3 ns c%0d", c), int'(NSLite), ns_e);
            check($sformatf("t3 ph c%0d", c), int'(phase_t), ph_e);
            check_excl(c);
            tick();
        end

        // 4: EW car steady, 1-cycle NS pulse at phase 1 -> no switch.
        do_reset();
        EWCar = 1'b1;
        NSCar = 1'b0;
        for (int c = 0; c < 20; c++) begin
            NSCar = (c == 1);
            check($sformatf("t4 ew c%0d", c), int'(EWLite), 2);
            check($sformatf("t4 ns c%0d", c), int'(NSLite), 0);
            check($sformatf("t4 ph c%0d", c), int'(phase_t), (c < 11) ? c : 11);
            tick();
        end
        NSCar = 1'b0;

        // 5: reset during NS yellow -> EW green, phase 0 on the next edge.
        do_reset();
        EWCar = 1'b0;
        NSCar = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c == 7) begin
                EWCar = 1'b1;
                NSCar = 1'b0;
            end
            tick();
        end
        check("t5 ns yel", int'(NSLite), 1);
        check("t5 ew yel", int'(EWLite), 0);
        reset = 1'b1;
        tick();
        check("t5 rst ew", int'(EWLite), 2);
        check("t5 rst ns", int'(NSLite), 0);
        check("t5 rst ph", int'(phase_t), 0);
        reset = 1'b0;
        EWCar = 1'b0;

`ifdef TRAFFIC_PED_EN
        // 6: ped pulse, no cars -> G 0-3, Y 4-5, walk 6-8, AR 9, NS green 10+.
        do_reset();
        check("t6 rst walk", int'(walk), 0);
        for (int c = 0; c < 14; c++) begin
            ped_req = (c == 0);
            ew_e = (c <= 3) ? 2 : (c <= 5) ? 1 : 0;
            ns_e = (c >= 10) ? 2 : 0;
            check($sformatf("t6 ew c%0d", c), int'(EWLite), ew_e);
            check($sformatf("t6 ns c%0d", c), int'(NSLite), ns_e);
            check($sformatf("t6 walk c%0d", c), int'(walk), (c >= 6 && c <= 8) ? 1 : 0);
            tick();
        end
        ped_req = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
